// File: rtl/regfile_write_demux.sv
// regfile_write_demux: write side of the general register bank.
//   Byte-masked writes into regs 1..NREG (reg 0 is never stored), registered one-hot
//   decode of the last accepted write, and a multi-cycle clear sweep that stalls the
//   valid/ready write port while it runs.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_wr_valid        write request present
//   o_wr_ready        write can be accepted this cycle (not sweeping)
//   i_wr_addr/data/mask  destination index, data, byte enables
//   i_clr_req         start a clear sweep (ignored while one is running)
//   o_busy            clear sweep in progress
//   o_zero_wr         pulse: accepted write targeted index 0 or > NREG
//   o_wr_onehot       decode of last accepted write address (bit 0 = index 0)
//   o_reg_flat        reg i at [W*(i-1) +: W]
module regfile_write_demux #(
  parameter int unsigned W    = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NREG = 31
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [W-1:0]      i_wr_data,
  input  logic [W/8-1:0]    i_wr_mask,
  input  logic              i_clr_req,
  output logic              o_busy,
  output logic              o_zero_wr,
  output logic [NREG:0]     o_wr_onehot,
  output logic [NREG*W-1:0] o_reg_flat
);

  localparam int unsigned IdxW = $clog2(NREG + 1);

  typedef enum logic [0:0] {StRun, StClear} state_e;

  state_e            r_state, w_state_d;
  logic [IdxW-1:0]   r_idx, w_idx_d;
  logic [W-1:0]      r_regs   [1:NREG];
  logic [W-1:0]      w_regs_d [1:NREG];
  logic              r_zero_wr;
  logic [NREG:0]     r_onehot;
  logic [NREG:0]     w_dec;
  logic              w_accept;
  logic              w_in_range;

  assign w_accept   = i_wr_valid && (r_state == StRun);
  assign w_in_range = (i_wr_addr != '0) && (i_wr_addr <= AW'(NREG));

  // Addresses above NREG match no bit, so the decode is all-zero for them.
  always_comb begin
    w_dec = '0;
    for (int i = 0; i <= int'(NREG); i++) begin
      w_dec[i] = (i_wr_addr == AW'(i));
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    unique case (r_state)
      StRun: begin
        if (i_clr_req) begin
          w_state_d = StClear;
          w_idx_d   = IdxW'(1);
        end
      end
      StClear: begin
        if (r_idx == IdxW'(NREG)) begin
          w_state_d = StRun;
          w_idx_d   = IdxW'(1);
        end else begin
          w_idx_d = r_idx + IdxW'(1);
        end
      end
      default: begin
        w_state_d = StRun;
        w_idx_d   = IdxW'(1);
      end
    endcase
  end

  // Sweep clears and writes are exclusive: writes are only accepted in StRun.
  always_comb begin
    for (int i = 1; i <= int'(NREG); i++) begin
      w_regs_d[i] = r_regs[i];
      if (r_state == StClear && r_idx == IdxW'(i)) begin
        w_regs_d[i] = '0;
      end else if (w_accept && i_wr_addr == AW'(i)) begin
        for (int b = 0; b < int'(W / 8); b++) begin
          if (i_wr_mask[b]) begin
            w_regs_d[i][8*b +: 8] = i_wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StRun;
      r_idx     <= IdxW'(1);
      r_zero_wr <= 1'b0;
      r_onehot  <= '0;
      for (int i = 1; i <= int'(NREG); i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_state   <= w_state_d;
      r_idx     <= w_idx_d;
      r_zero_wr <= w_accept && !w_in_range;
      if (w_accept) begin
        r_onehot <= w_dec;
      end
      for (int i = 1; i <= int'(NREG); i++) begin
        r_regs[i] <= w_regs_d[i];
      end
    end
  end

  assign o_wr_ready  = (r_state == StRun);
  assign o_busy      = (r_state == StClear);
  assign o_zero_wr   = r_zero_wr;
  assign o_wr_onehot = r_onehot;

  for (genvar g = 1; g <= int'(NREG); g++) begin : g_flat
    assign o_reg_flat[W*(g-1) +: W] = r_regs[g];
  end

endmodule

// File: tb/tb_regfile_write_demux.sv
module tb_regfile_write_demux;
  localparam int W    = 32;
  localparam int AW   = 5;
  localparam int NREG = 31;

  logic              clk = 1'b0;
  logic              i_rst, i_wr_valid, i_clr_req;
  logic [AW-1:0]     i_wr_addr;
  logic [W-1:0]      i_wr_data;
  logic [W/8-1:0]    i_wr_mask;
  logic              o_wr_ready, o_busy, o_zero_wr;
  logic [NREG:0]     o_wr_onehot;
  logic [NREG*W-1:0] o_reg_flat;

  always #5 clk = ~clk;

  regfile_write_demux #(.W(W), .AW(AW), .NREG(NREG)) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_wr_valid (i_wr_valid),
    .o_wr_ready (o_wr_ready),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .i_wr_mask  (i_wr_mask),
    .i_clr_req  (i_clr_req),
    .o_busy     (o_busy),
    .o_zero_wr  (o_zero_wr),
    .o_wr_onehot(o_wr_onehot),
    .o_reg_flat (o_reg_flat)
  );

  // Reference model: register array, cycles of sweep remaining, last-write flags.
  logic [W-1:0]  m_regs [0:NREG];
  int            m_left = 0;
  logic          m_zero = 1'b0;
  logic [NREG:0] m_onehot = '0;

  int  n_cmp = 0;
  int  n_bad = 0;
  bit  chk_en = 1'b0;

  task automatic chk(input string nm, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] at %0t: got %0h, want %0h", nm, idx, $time, act, exp);
    end
  endtask

  function automatic logic [W-1:0] dut_reg(input int r);
    return o_reg_flat[W*(r-1) +: W];
  endfunction

  task automatic model_update();
    bit acc;
    logic [NREG:0] one;
    if (i_rst) begin
      for (int r = 0; r <= NREG; r++) m_regs[r] = '0;
      m_left   = 0;
      m_zero   = 1'b0;
      m_onehot = '0;
    end else begin
      acc = i_wr_valid && (m_left == 0);
      if (m_left > 0) begin
        // Sweep clears regs 1..NREG in order, one per cycle.
        m_regs[NREG - m_left + 1] = '0;
        m_left--;
      end else if (i_clr_req) begin
        m_left = NREG;
      end
      if (acc) begin
        if (i_wr_addr >= 1 && int'(i_wr_addr) <= NREG) begin
          for (int b = 0; b < W / 8; b++)
            if (i_wr_mask[b]) m_regs[i_wr_addr][8*b +: 8] = i_wr_data[8*b +: 8];
          m_zero = 1'b0;
        end else begin
          m_zero = 1'b1;
        end
        one = 1;
        m_onehot = (int'(i_wr_addr) <= NREG) ? (one << i_wr_addr) : '0;
      end else begin
        m_zero = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wr_ready", 0, 64'(o_wr_ready), 64'(m_left == 0));
      chk("busy", 0, 64'(o_busy), 64'(m_left != 0));
      chk("zero_wr", 0, 64'(o_zero_wr), 64'(m_zero));
      chk("wr_onehot", 0, 64'(o_wr_onehot), 64'(m_onehot));
      for (int r = 1; r <= NREG; r++) chk("reg", r, 64'(dut_reg(r)), 64'(m_regs[r]));
    end
  end

  task automatic set_wr(input bit v, input int a, input logic [W-1:0] d, input logic [3:0] m);
    i_wr_valid = v;
    i_wr_addr  = AW'(a);
    i_wr_data  = d;
    i_wr_mask  = m;
  endtask

  task automatic fill_all();
    for (int a = 1; a <= NREG; a++) begin
      set_wr(1'b1, a, {8'(a), 24'hA5C3E1}, 4'hF);
      cyc();
    end
    i_wr_valid = 1'b0;
  endtask

  int n;

  initial begin
    i_rst = 1'b1; i_clr_req = 1'b0;
    set_wr(1'b0, 0, '0, 4'h0);
    cyc();
    chk_en = 1'b1;
    i_rst = 1'b0;
    chk("reset_busy", 0, 64'(o_busy), 64'd0);
    chk("reset_ready", 0, 64'(o_wr_ready), 64'd1);
    chk("reset_onehot", 0, 64'(o_wr_onehot), 64'd0);
    chk("reset_zero_wr", 0, 64'(o_zero_wr), 64'd0);

    // Full write to reg 5.
    set_wr(1'b1, 5, 32'hDEADBEEF, 4'hF);
    cyc();
    i_wr_valid = 1'b0;
    chk("t1_reg5", 5, 64'(o_reg_flat[159:128]), 64'hDEADBEEF);
    chk("t1_onehot", 0, 64'(o_wr_onehot), 64'h20);
    chk("t1_reg6", 6, 64'(dut_reg(6)), 64'd0);

    // Byte-masked write.
    set_wr(1'b1, 5, 32'h11223344, 4'b0101);
    cyc();
    i_wr_valid = 1'b0;
    chk("t2_reg5", 5, 64'(dut_reg(5)), 64'hDE22BE44);

    // Write to index 0.
    set_wr(1'b1, 0, 32'hFFFFFFFF, 4'hF);
    cyc();
    i_wr_valid = 1'b0;
    chk("t3_zero_wr", 0, 64'(o_zero_wr), 64'd1);
    chk("t3_onehot", 0, 64'(o_wr_onehot), 64'd1);
    chk("t3_reg5", 5, 64'(dut_reg(5)), 64'hDE22BE44);
    cyc();
    chk("t3_zero_wr_drop", 0, 64'(o_zero_wr), 64'd0);
    chk("t3_onehot_hold", 0, 64'(o_wr_onehot), 64'd1);

    // Clear sweep with a same-cycle write to reg 31.
    fill_all();
    i_clr_req = 1'b1;
    set_wr(1'b1, 31, 32'h12345678, 4'hF);
    cyc();
    i_clr_req = 1'b0;
    i_wr_valid = 1'b0;
    chk("t4_reg31_written", 31, 64'(dut_reg(31)), 64'h12345678);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (!o_busy) break;
      n++;
      cyc();
    end
    chk("t4_busy_cycles", 0, 64'(n), 64'd31);
    for (int r = 1; r <= NREG; r++) chk("t4_cleared", r, 64'(dut_reg(r)), 64'd0);

    // Write held across a sweep.
    i_clr_req = 1'b1;
    cyc();
    i_clr_req = 1'b0;
    set_wr(1'b1, 7, 32'd7, 4'hF);
    n = 0;
    while (!o_wr_ready && n < 100) begin
      cyc();
      n++;
    end
    chk("t5_wait_cycles", 0, 64'(n), 64'd31);
    chk("t5_reg7_before", 7, 64'(dut_reg(7)), 64'd0);
    cyc();
    i_wr_valid = 1'b0;
    chk("t5_reg7_after", 7, 64'(dut_reg(7)), 64'd7);

    // Reset in the middle of a sweep (index 10).
    fill_all();
    i_clr_req = 1'b1;
    cyc();
    i_clr_req = 1'b0;
    for (int k = 0; k < 9; k++) cyc();
    chk("t6_reg11_live", 11, 64'(dut_reg(11)), 64'h0BA5C3E1);
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    chk("t6_busy", 0, 64'(o_busy), 64'd0);
    chk("t6_ready", 0, 64'(o_wr_ready), 64'd1);
    for (int r = 1; r <= NREG; r++) chk("t6_regs", r, 64'(dut_reg(r)), 64'd0);

    // Randomised traffic; fields held while a request is waiting.
    for (int k = 0; k < 3000; k++) begin
      i_rst     = ($urandom_range(0, 199) == 0);
      i_clr_req = ($urandom_range(0, 39) == 0);
      if (!(i_wr_valid && m_left > 0)) begin
        set_wr(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom,
               4'($urandom_range(0, 15)));
      end
      cyc();
    end
    i_rst = 1'b0; i_clr_req = 1'b0; i_wr_valid = 1'b0;
    cyc();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
